// File: rtl/frame101_pkg.sv
// Shared types and constants for the "101" sync-pattern serial frame transmitter.
// State PARITY is always declared; it is only reachable when FRAME101_PARITY_EN is defined.
package frame101_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_A,
    PRE_B,
    PRE_C,
    DATA,
    PARITY,
    GUARD
  } state_t;

  localparam logic [2:0] PREAMBLE  = 3'b101;
  localparam logic       GUARD_BIT = 1'b0;

endpackage

// File: rtl/frame101_shift.sv
// Loadable left-shift payload register with a bit counter.
// The last output flags the final payload bit of the frame.
module frame101_shift #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb,
  output logic              last
);

  localparam int                CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign msb  = sr_q[DATA_W-1];
  assign last = (cnt_q == LAST_CNT);

  always_comb begin
    // NOTE: defaults first so every path assigns sr_d/cnt_d and no latch is inferred.
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load) begin
      sr_d  = din;
      cnt_d = '0;
    end else if (shift) begin
      sr_d  = sr_q << 1;
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame101_tx.sv
// Serial frame transmitter: preamble 1,0,1, payload MSB first, optional parity, guard 0.
// Build option: define FRAME101_PARITY_EN to insert an even-parity bit before the guard.
module frame101_tx
  import frame101_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              out,
  output logic              busy,
  output logic              sync
);

  state_t state_q, state_d;
  logic   load, shift, sr_msb, sr_last;

  frame101_shift #(.DATA_W(DATA_W)) u_shift (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (data),
    .msb   (sr_msb),
    .last  (sr_last)
  );

`ifdef FRAME101_PARITY_EN
  logic parity_q;

  // Parity is captured with the word so later changes on data cannot affect it.
  always_ff @(posedge clk) begin
    if (reset)     parity_q <= 1'b0;
    else if (load) parity_q <= ^data;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    out     = GUARD_BIT;
    sync    = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (valid) begin
          load    = 1'b1;
          state_d = PRE_A;
        end
      end
      PRE_A: begin
        out     = PREAMBLE[2];
        sync    = 1'b1;
        state_d = PRE_B;
      end
      PRE_B: begin
        out     = PREAMBLE[1];
        sync    = 1'b1;
        state_d = PRE_C;
      end
      PRE_C: begin
        out     = PREAMBLE[0];
        sync    = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        out   = sr_msb;
        shift = 1'b1;
        if (sr_last) begin
`ifdef FRAME101_PARITY_EN
          state_d = PARITY;
`else
          state_d = GUARD;
`endif
        end
      end
      PARITY: begin
`ifdef FRAME101_PARITY_EN
        out = parity_q;
`endif
        state_d = GUARD;
      end
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame101_tx.sv
// Scoreboard bench for frame101_tx: expected per-cycle line state is queued when
// stimulus is driven and compared against the DUT on every falling edge.
module tb_frame101_tx;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] data = '0;
  logic              valid = 1'b0;
  logic              ready, out, busy, sync;

  typedef struct packed {
    logic out;
    logic sync;
    logic busy;
    logic ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  frame101_tx #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .data  (data),
    .valid (valid),
    .ready (ready),
    .out   (out),
    .busy  (busy),
    .sync  (sync)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_chk += 4;
      if (out !== e.out) begin
        n_err++;
        $display("FAIL out cycle %0d: got %b expected %b", cyc, out, e.out);
      end
      if (sync !== e.sync) begin
        n_err++;
        $display("FAIL sync cycle %0d: got %b expected %b", cyc, sync, e.sync);
      end
      if (busy !== e.busy) begin
        n_err++;
        $display("FAIL busy cycle %0d: got %b expected %b", cyc, busy, e.busy);
      end
      if (ready !== e.ready) begin
        n_err++;
        $display("FAIL ready cycle %0d: got %b expected %b", cyc, ready, e.ready);
      end
    end
  end

  function automatic exp_t mk(input logic o, input logic s, input logic b, input logic r);
    exp_t e;
    e.out = o; e.sync = s; e.busy = b; e.ready = r;
    return e;
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  // Reference frame: 1,0,1, payload MSB first, [even parity], guard 0.
  // Only the first n cycles are queued, so an aborted frame can be modelled.
  task automatic push_frame(input logic [DATA_W-1:0] w, input int n);
    exp_t f[$];
    f.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0));
    f.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0));
    f.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0));
    for (int k = 0; k < DATA_W; k++) f.push_back(mk(w[DATA_W-1-k], 1'b0, 1'b1, 1'b0));
`ifdef FRAME101_PARITY_EN
    f.push_back(mk(^w, 1'b0, 1'b1, 1'b0));
`endif
    f.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
    for (int i = 0; i < n && i < f.size(); i++) exp_q.push_back(f[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s drain: %0d entries left, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid = 1'b0;
    step();
    step();
    reset = 1'b0;
    push_idle(5);
    wait_drain("reset", 20);
  endtask

  task automatic test_frame(input logic [DATA_W-1:0] w);
    step();
    valid = 1'b1;
    data  = w;
    push_idle(1);
    push_frame(w, 100);
    push_idle(2);
    step();
    valid = 1'b0;
    data  = DATA_W'($urandom);
    wait_drain("frame", 60);
  endtask

  task automatic test_back_to_back();
    step();
    valid = 1'b1;
    data  = {DATA_W{1'b1}};
    push_idle(1);
    push_frame({DATA_W{1'b1}}, 100);
    push_idle(1);
    push_frame('0, 100);
    push_idle(2);
    step();
    data = '0;
    repeat (14) step();
    valid = 1'b0;
    wait_drain("back_to_back", 60);
  endtask

  task automatic test_ignore_busy();
    step();
    valid = 1'b1;
    data  = 8'hA5;
    push_idle(1);
    push_frame(8'hA5, 100);
    push_idle(3);
    step();
    valid = 1'b0;
    step();
    step();
    valid = 1'b1;
    data  = 8'h3C;
    repeat (3) step();
    valid = 1'b0;
    wait_drain("ignore_busy", 60);
  endtask

  task automatic test_reset_mid_frame();
    step();
    valid = 1'b1;
    data  = 8'hA5;
    push_idle(1);
    push_frame(8'hA5, 6);
    push_idle(2);
    push_frame(8'h5A, 100);
    push_idle(2);
    step();
    valid = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    valid = 1'b1;
    data  = 8'h5A;
    step();
    valid = 1'b0;
    wait_drain("reset_mid_frame", 60);
  endtask

  task automatic test_reset_with_valid();
    step();
    reset = 1'b1;
    valid = 1'b1;
    data  = 8'hC3;
    push_idle(1);
    step();
    reset = 1'b0;
    valid = 1'b0;
    push_idle(3);
    wait_drain("reset_with_valid", 20);
  endtask

  initial begin
    test_reset();
    test_frame(8'hA5);
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid_frame();
    test_reset_with_valid();
    test_frame(8'h07);
    test_frame(8'h03);
    test_frame(8'h80);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
